// File: rtl/color_mapper_if.sv
// color_mapper_if: pixel, mode, frame and palette-write inputs plus the colour output of the colour mapper.
interface color_mapper_if #(
    parameter int CW      = 10,
    parameter int COORD_W = 11
);
    logic               enable;
    logic [1:0]         px_class;
    logic [1:0]         mode;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               frame_start;
    logic               pal_we;
    logic [1:0]         pal_addr;
    logic [3*CW-1:0]    pal_wdata;
    logic [3*CW-1:0]    color_data;
    logic               color_valid;
    modport master (
        output enable, px_class, mode, x, y, frame_start, pal_we, pal_addr, pal_wdata,
        input  color_data, color_valid
    );
    modport slave (
        input  enable, px_class, mode, x, y, frame_start, pal_we, pal_addr, pal_wdata,
        output color_data, color_valid
    );
endinterface

// File: rtl/color_mapper.sv
// color_mapper: 2-stage pixel colouriser with a writable 4-entry palette and palette/invert/gradient/blink modes.
module color_mapper #(
    parameter int CW           = 10,
    parameter int COORD_W      = 11,
    parameter int BLINK_FRAMES = 30
) (
    input logic          clk,
    input logic          rst,
    color_mapper_if.slave bus
);
    localparam int W  = 3 * CW;
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [FW-1:0] LAST = FW'(BLINK_FRAMES - 1);

    function automatic logic [CW-1:0] top4(input logic [3:0] v);
        return CW'(v) << (CW - 4);
    endfunction

    logic [W-1:0]       pal [4];
    logic [FW-1:0]      cnt;
    logic               phase;
    logic               s1_valid;
    logic [1:0]         s1_mode;
    logic [1:0]         s1_cls;
    logic [COORD_W-1:0] s1_y;
    logic [W-1:0]       s1_col;
    logic [W-1:0]       s1_bg;
    logic [CW-1:0]      grad_b;
    logic               blank;
    logic [W-1:0]       nxt;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pal[0] <= {top4(4'hD), top4(4'h5), top4(4'h3)};
            pal[1] <= '1;
            pal[2] <= {{CW{1'b0}}, {CW{1'b1}}, {CW{1'b0}}};
            pal[3] <= {top4(4'h8), top4(4'h8), top4(4'h8)};
        end else if (bus.pal_we)
            pal[bus.pal_addr] <= bus.pal_wdata;

    // blink_phase flips each time the counter wraps
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (bus.frame_start) begin
            cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
            phase <= phase ^ (cnt == LAST);
        end

    always_ff @(posedge clk)
        if (bus.enable) begin
            s1_mode <= bus.mode;
            s1_cls  <= bus.px_class;
            s1_y    <= bus.y;
            s1_col  <= pal[bus.px_class];
            s1_bg   <= pal[0];
        end

    always_comb begin
        grad_b = |(s1_y >> CW) ? '1 : CW'(s1_y);
        blank  = phase && (s1_cls == 2'd1 || s1_cls == 2'd2);
        nxt    = !s1_valid      ? '0 :
                 s1_mode == 2'd0 ? s1_col :
                 s1_mode == 2'd1 ? ~s1_col :
                 s1_mode == 2'd2 ? (s1_cls == 2'd0 ? {s1_bg[W-1:CW], grad_b} : s1_col) :
                 blank           ? s1_bg : s1_col;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1_valid        <= 1'b0;
            bus.color_valid <= 1'b0;
            bus.color_data  <= '0;
        end else begin
            s1_valid        <= bus.enable;
            bus.color_valid <= s1_valid;
            bus.color_data  <= nxt;
        end
endmodule

// File: tb/tb_color_mapper.sv
// tb_color_mapper: directed vectors with hand-computed colours, checked 2 clocks after each input.
module tb_color_mapper;
    localparam logic [29:0] E0    = 30'h340500C0;
    localparam logic [29:0] E1    = 30'h3FFFFFFF;
    localparam logic [29:0] E2    = 30'h000FFC00;
    localparam logic [29:0] E3    = 30'h20080200;
    localparam logic [29:0] NEW2  = 30'h00ABCDEF;
    localparam logic [29:0] INV0  = 30'h0BFAFF3F;
    localparam logic [29:0] G200  = 30'h340500C8;
    localparam logic [29:0] G0    = 30'h34050000;
    localparam logic [29:0] GSAT  = 30'h340503FF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic        ev  [2];
    logic [29:0] edq [2];
    string       tq  [2];

    always #5 clk = ~clk;

    color_mapper_if #(.CW(10), .COORD_W(11)) bus ();

    color_mapper #(.CW(10), .COORD_W(11), .BLINK_FRAMES(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic flush_exp();
        for (int i = 0; i < 2; i++) begin
            ev[i]  = 1'b0;
            edq[i] = '0;
            tq[i]  = "idle";
        end
    endtask

    // check the pixel driven two steps ago, then drive this step's inputs for one clock
    task automatic step(input string tag, input logic en, input logic [1:0] cls, input logic [1:0] md,
                        input logic [10:0] yv, input logic fs, input logic [29:0] ed);
        check({tq[1], " valid"}, {31'd0, bus.color_valid}, {31'd0, ev[1]});
        check({tq[1], " data"}, {2'd0, bus.color_data}, {2'd0, edq[1]});
        ev[1]  = ev[0];
        edq[1] = edq[0];
        tq[1]  = tq[0];
        ev[0]  = en;
        edq[0] = en ? ed : 30'd0;
        tq[0]  = tag;
        bus.enable      = en;
        bus.px_class    = cls;
        bus.mode        = md;
        bus.y           = yv;
        bus.frame_start = fs;
        @(negedge clk);
        bus.pal_we      = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 1'b0, 2'd0, 2'd0, 11'd0, 1'b0, 30'd0);
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) step("fs", 1'b0, 2'd0, 2'd0, 11'd0, 1'b1, 30'd0);
    endtask

    initial begin
        bus.enable = 1'b0; bus.px_class = '0; bus.mode = '0; bus.x = '0; bus.y = '0;
        bus.frame_start = 1'b0; bus.pal_we = 1'b0; bus.pal_addr = '0; bus.pal_wdata = '0;
        flush_exp();
        repeat (3) @(negedge clk);
        check("reset valid", {31'd0, bus.color_valid}, 32'd0);
        check("reset data", {2'd0, bus.color_data}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        step("rst pal0", 1, 2'd0, 2'd0, 11'd0, 0, E0);
        step("rst pal1", 1, 2'd1, 2'd0, 11'd0, 0, E1);
        step("rst pal3", 1, 2'd3, 2'd0, 11'd0, 0, E3);
        idle(2);

        bus.pal_we = 1'b1; bus.pal_addr = 2'd2; bus.pal_wdata = NEW2;
        step("coll old", 1, 2'd2, 2'd0, 11'd0, 0, E2);
        step("coll new", 1, 2'd2, 2'd0, 11'd0, 0, NEW2);
        idle(2);

        step("inv cls1", 1, 2'd1, 2'd1, 11'd0, 0, 30'd0);
        step("inv cls0", 1, 2'd0, 2'd1, 11'd0, 0, INV0);
        step("grad 200", 1, 2'd0, 2'd2, 11'd200, 0, G200);
        step("grad 0", 1, 2'd0, 2'd2, 11'd0, 0, G0);
        step("grad 1023", 1, 2'd0, 2'd2, 11'd1023, 0, GSAT);
        step("grad 1024", 1, 2'd0, 2'd2, 11'd1024, 0, GSAT);
        step("grad 1500", 1, 2'd0, 2'd2, 11'd1500, 0, GSAT);
        step("grad cls1", 1, 2'd1, 2'd2, 11'd1500, 0, E1);
        idle(2);

        step("blink ph0 cls1", 1, 2'd1, 2'd3, 11'd0, 0, E1);
        pulse(3);
        step("blink ph1 cls1", 1, 2'd1, 2'd3, 11'd0, 0, E0);
        step("blink ph1 cls2", 1, 2'd2, 2'd3, 11'd0, 0, E0);
        step("blink ph1 cls3", 1, 2'd3, 2'd3, 11'd0, 0, E3);
        step("blink ph1 cls0", 1, 2'd0, 2'd3, 11'd0, 0, E0);
        step("mode0 ph1 cls1", 1, 2'd1, 2'd0, 11'd0, 0, E1);
        pulse(2);
        step("blink fs+pix", 1, 2'd1, 2'd3, 11'd0, 1, E1);
        step("blink ph0 cls2", 1, 2'd2, 2'd3, 11'd0, 0, NEW2);
        step("blink ph0 cls3", 1, 2'd3, 2'd3, 11'd0, 0, E3);
        idle(2);

        for (int i = 0; i < 8; i++) begin
            logic [1:0]  c;
            logic [29:0] e;
            c = 2'(i);
            e = (c == 2'd0) ? E0 : (c == 2'd1) ? E1 : (c == 2'd2) ? NEW2 : E3;
            step("stream", 1, c, 2'd0, 11'd0, 0, e);
        end
        step("gap", 0, 2'd1, 2'd0, 11'd0, 0, 30'd0);
        step("stream tail1", 1, 2'd1, 2'd0, 11'd0, 0, E1);
        step("stream tail3", 1, 2'd3, 2'd0, 11'd0, 0, E3);
        idle(2);

        pulse(1);
        step("pre-rst a", 1, 2'd1, 2'd0, 11'd0, 0, E1);
        step("pre-rst b", 1, 2'd2, 2'd0, 11'd0, 0, NEW2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst valid", {31'd0, bus.color_valid}, 32'd0);
        check("arst data", {2'd0, bus.color_data}, 32'd0);
        bus.enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        flush_exp();
        @(negedge clk);
        step("post-rst pal2", 1, 2'd2, 2'd0, 11'd0, 0, E2);
        pulse(2);
        step("post-rst cnt", 1, 2'd1, 2'd3, 11'd0, 0, E1);
        pulse(1);
        step("post-rst wrap", 1, 2'd1, 2'd3, 11'd0, 0, E0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
